// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO register file: register map, warm-up states, defaults.
package gpio_pkg;

  localparam logic [2:0] GPIO_ADDR_TRISTATE = 3'd0;
  localparam logic [2:0] GPIO_ADDR_DATAREG  = 3'd1;
  localparam logic [2:0] GPIO_ADDR_PINSTATE = 3'd2;
  localparam logic [2:0] GPIO_ADDR_MASK     = 3'd3;
  localparam logic [2:0] GPIO_ADDR_STATUS   = 3'd4;
  localparam logic [2:0] GPIO_ADDR_POL      = 3'd5;
  localparam logic [2:0] GPIO_ADDR_ANY      = 3'd6;
  localparam logic [2:0] GPIO_ADDR_ID       = 3'd7;

  localparam logic [7:0] GPIO_VERSION_DEFAULT = 8'h02;

  typedef enum logic [1:0] {WARM0, WARM1, WARM2, RUN} warm_state_e;

  // Expand 4 byte enables into a 32-bit bit mask.
  function automatic logic [31:0] gpio_byte_mask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Pin synchroniser, previous-value register and interrupt status set generation.
// Edge detection when GPIO_EDGE_IRQ_EN is defined, level detection otherwise.
module gpio_sync_edge #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic [WIDTH-1:0] pin_async,
  input  logic [WIDTH-1:0] pol,
  input  logic [WIDTH-1:0] any,
  output logic [WIDTH-1:0] pin_sync,
  output logic [WIDTH-1:0] set_vec
);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] prev_q, prev_d;

  always_comb begin
    sync1_d = pin_async;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign pin_sync = sync2_q;

`ifdef GPIO_EDGE_IRQ_EN
  logic [WIDTH-1:0] rise, fall, hit;

  always_comb begin
    rise    = sync2_q & ~prev_q;
    fall    = ~sync2_q & prev_q;
    // any-edge overrides polarity; otherwise pol picks falling (1) or rising (0)
    hit     = (any & (rise | fall)) | (~any & ~pol & rise) | (~any & pol & fall);
    set_vec = run ? hit : '0;
  end
`else
  logic unused_edge;
  assign unused_edge = ^{prev_q, any};

  always_comb begin
    set_vec = run ? (sync2_q ^ pol) : '0;
  end
`endif

endmodule

// File: rtl/gpio_regfile.sv
// Parametrised GPIO register file: bus decode, byte-enabled writes, warm-up FSM, irq.
// Define GPIO_EDGE_IRQ_EN for sticky edge interrupts; default build is level mode.
module gpio_regfile
  import gpio_pkg::*;
#(
  parameter int         WIDTH   = 16,
  parameter logic [7:0] VERSION = GPIO_VERSION_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cs,
  input  logic [4:2]       addr,
  input  logic             r_wn,
  input  logic [3:0]       wben,
  input  logic [31:0]      wdata,
  input  logic [WIDTH-1:0] ro_gpio_pinstate,
  output logic [31:0]      rdata,
  output logic [WIDTH-1:0] rf_gpio_tristate,
  output logic [WIDTH-1:0] rf_gpio_datareg,
  output logic [WIDTH-1:0] rf_gpio_interrupt_mask,
  output logic             irq
);

  logic [WIDTH-1:0] tristate_q, tristate_d;
  logic [WIDTH-1:0] datareg_q, datareg_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] status_q, status_d;
  logic [WIDTH-1:0] pol_q, pol_d;
  logic [WIDTH-1:0] any_q, any_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             irq_q, irq_d;
  warm_state_e      state_q, state_d;

  logic             wr, rd, run;
  logic [31:0]      bmask32;
  logic [WIDTH-1:0] bmask, wdat, w1c;
  logic [WIDTH-1:0] pin_sync, set_vec;
  logic             unused_bus;

  assign wr         = cs & ~r_wn;
  assign rd         = cs & r_wn;
  assign run        = (state_q == RUN);
  assign bmask32    = gpio_byte_mask(wben);
  assign bmask      = bmask32[WIDTH-1:0];
  assign wdat       = wdata[WIDTH-1:0];
  assign unused_bus = ^{bmask32, wdata};

  function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old,
                                             input logic [WIDTH-1:0] dat,
                                             input logic [WIDTH-1:0] m);
    return (old & ~m) | (dat & m);
  endfunction

  gpio_sync_edge #(.WIDTH(WIDTH)) u_sync_edge (
    .clock     (clock),
    .reset     (reset),
    .run       (run),
    .pin_async (ro_gpio_pinstate),
    .pol       (pol_q),
    .any       (any_q),
    .pin_sync  (pin_sync),
    .set_vec   (set_vec)
  );

  always_comb begin
    tristate_d = tristate_q;
    datareg_d  = datareg_q;
    mask_d     = mask_q;
    pol_d      = pol_q;
    any_d      = any_q;
    w1c        = '0;
    if (wr) begin
      case (addr)
        GPIO_ADDR_TRISTATE: tristate_d = merge(tristate_q, wdat, bmask);
        GPIO_ADDR_DATAREG:  datareg_d  = merge(datareg_q, wdat, bmask);
        GPIO_ADDR_MASK:     mask_d     = merge(mask_q, wdat, bmask);
        GPIO_ADDR_STATUS:   w1c        = wdat & bmask;
        GPIO_ADDR_POL:      pol_d      = merge(pol_q, wdat, bmask);
`ifdef GPIO_EDGE_IRQ_EN
        GPIO_ADDR_ANY:      any_d      = merge(any_q, wdat, bmask);
`endif
        default: ;
      endcase
    end

`ifdef GPIO_EDGE_IRQ_EN
    // hardware set wins over a same-cycle clear
    status_d = (status_q & ~w1c) | set_vec;
`else
    status_d = set_vec;
`endif

    case (state_q)
      WARM0:   state_d = WARM1;
      WARM1:   state_d = WARM2;
      default: state_d = RUN;
    endcase

    rdata_d = rdata_q;
    if (rd) begin
      case (addr)
        GPIO_ADDR_TRISTATE: rdata_d = 32'(tristate_q);
        GPIO_ADDR_DATAREG:  rdata_d = 32'(datareg_q);
        GPIO_ADDR_PINSTATE: rdata_d = 32'(pin_sync);
        GPIO_ADDR_MASK:     rdata_d = 32'(mask_q);
        GPIO_ADDR_STATUS:   rdata_d = 32'(status_q);
        GPIO_ADDR_POL:      rdata_d = 32'(pol_q);
        GPIO_ADDR_ANY:      rdata_d = 32'(any_q);
        default:            rdata_d = {8'h0, VERSION, 10'h0, 6'(WIDTH)};
      endcase
    end

    irq_d = |(status_q & mask_q);
  end

`ifndef GPIO_EDGE_IRQ_EN
  logic unused_w1c;
  assign unused_w1c = ^w1c;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tristate_q <= '0;
      datareg_q  <= '0;
      mask_q     <= '0;
      status_q   <= '0;
      pol_q      <= '0;
      any_q      <= '0;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
      state_q    <= WARM0;
    end else begin
      tristate_q <= tristate_d;
      datareg_q  <= datareg_d;
      mask_q     <= mask_d;
      status_q   <= status_d;
      pol_q      <= pol_d;
      any_q      <= any_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
      state_q    <= state_d;
    end
  end

  assign rdata                  = rdata_q;
  assign irq                    = irq_q;
  assign rf_gpio_tristate       = tristate_q;
  assign rf_gpio_datareg        = datareg_q;
  assign rf_gpio_interrupt_mask = mask_q;

endmodule

// File: tb/tb_gpio_regfile.sv
// Self-checking bench for gpio_regfile: WIDTH=16 and WIDTH=8 instances, read scoreboard.
module tb_gpio_regfile;
  import gpio_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        cs, cs8, r_wn;
  logic [4:2]  addr;
  logic [3:0]  wben;
  logic [31:0] wdata;
  logic [15:0] pins;
  logic [7:0]  pins8;

  logic [31:0] rdata, rdata8;
  logic [15:0] tri16, dat16, msk16;
  logic [7:0]  tri8, dat8, msk8;
  logic        irq, irq8;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        sel8;
    logic [31:0] exp;
    string       nm;
  } rd_exp_t;

  rd_exp_t sb[$];

  always #5 clock = ~clock;

  gpio_regfile #(.WIDTH(16)) dut (
    .clock(clock), .reset(reset), .cs(cs), .addr(addr), .r_wn(r_wn), .wben(wben),
    .wdata(wdata), .ro_gpio_pinstate(pins), .rdata(rdata), .rf_gpio_tristate(tri16),
    .rf_gpio_datareg(dat16), .rf_gpio_interrupt_mask(msk16), .irq(irq)
  );

  gpio_regfile #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .cs(cs8), .addr(addr), .r_wn(r_wn), .wben(wben),
    .wdata(wdata), .ro_gpio_pinstate(pins8), .rdata(rdata8), .rf_gpio_tristate(tri8),
    .rf_gpio_datareg(dat8), .rf_gpio_interrupt_mask(msk8), .irq(irq8)
  );

  // Scoreboard consumer: a read accepted on an edge is compared just after it.
  always @(posedge clock) begin
    logic    was_rd;
    rd_exp_t e;
    logic [31:0] got;
    was_rd = (cs | cs8) & r_wn;
    if (was_rd) begin
      #1;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: read seen with no expected value");
      end else begin
        e   = sb.pop_front();
        got = e.sel8 ? rdata8 : rdata;
        if (got !== e.exp) begin
          errors++;
          $display("FAIL %s: rdata=%h expected %h", e.nm, got, e.exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic bus_write(input logic sel8, input logic [2:0] a, input logic [3:0] be,
                           input logic [31:0] d);
    cs = !sel8; cs8 = sel8; r_wn = 1'b0; addr = a; wben = be; wdata = d;
    tick();
    cs = 1'b0; cs8 = 1'b0;
  endtask

  task automatic bus_read(input logic sel8, input logic [2:0] a, input logic [31:0] exp,
                          input string nm);
    rd_exp_t e;
    e.sel8 = sel8; e.exp = exp; e.nm = nm;
    sb.push_back(e);
    cs = !sel8; cs8 = sel8; r_wn = 1'b1; addr = a; wben = 4'h0;
    tick();
    cs = 1'b0; cs8 = 1'b0; r_wn = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cs = 1'b0; cs8 = 1'b0; r_wn = 1'b0; addr = 3'd0; wben = 4'h0;
    wdata = '0; pins = 16'hFFFF; pins8 = 8'hFF;
    #12;
    checks++;
    if ({rdata, irq, tri16, dat16, msk16} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rdata=%h irq=%b tri=%h dat=%h msk=%h expected all 0",
               rdata, irq, tri16, dat16, msk16);
    end
    checks++;
    if ({rdata8, irq8, tri8, dat8, msk8} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_w8: rdata=%h irq=%b expected 0", rdata8, irq8);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (3) tick();
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL warmup_irq: irq=%b expected 0", irq);
    end
    bus_read(0, GPIO_ADDR_STATUS, 32'h0, "warmup_status");
    bus_read(0, GPIO_ADDR_ID, 32'h0002_0010, "id_w16");
    bus_read(1, GPIO_ADDR_ID, 32'h0002_0008, "id_w8");
  endtask

  task automatic test_byte_write();
    bus_write(0, GPIO_ADDR_DATAREG, 4'b0001, 32'hA5A5_1234);
    checks++;
    if (dat16 !== 16'h0034) begin
      errors++;
      $display("FAIL datareg_byte0: dat=%h expected 0034", dat16);
    end
    bus_read(0, GPIO_ADDR_DATAREG, 32'h0000_0034, "datareg_read");
    bus_write(0, GPIO_ADDR_DATAREG, 4'b0010, 32'h0000_5600);
    bus_read(0, GPIO_ADDR_DATAREG, 32'h0000_5634, "datareg_byte1_merge");
    bus_write(0, GPIO_ADDR_TRISTATE, 4'b0011, 32'h1234_BEEF);
    checks++;
    if (tri16 !== 16'hBEEF) begin
      errors++;
      $display("FAIL tristate_write: tri=%h expected beef", tri16);
    end
  endtask

  task automatic test_readonly();
    bus_write(0, GPIO_ADDR_PINSTATE, 4'hF, 32'h0);
    bus_read(0, GPIO_ADDR_PINSTATE, 32'h0000_FFFF, "pinstate_ro");
    bus_write(0, GPIO_ADDR_ID, 4'hF, 32'h0);
    bus_read(0, GPIO_ADDR_ID, 32'h0002_0010, "id_ro");
    tick();
    checks++;
    if (rdata !== 32'h0002_0010) begin
      errors++;
      $display("FAIL rdata_hold: rdata=%h expected 00020010", rdata);
    end
  endtask

`ifdef GPIO_EDGE_IRQ_EN
  task automatic test_edge_rise();
    pins[3] = 1'b0;
    repeat (4) tick();
    bus_read(0, GPIO_ADDR_STATUS, 32'h0, "falling_ignored");
    bus_write(0, GPIO_ADDR_MASK, 4'b0011, 32'h0000_0008);
    pins[3] = 1'b1;
    repeat (3) tick();
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_early: irq=%b expected 0 at k+2", irq);
    end
    tick();
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_rise: irq=%b expected 1 at k+3", irq);
    end
    bus_read(0, GPIO_ADDR_STATUS, 32'h0000_0008, "status_rise");
    bus_write(0, GPIO_ADDR_STATUS, 4'b0001, 32'h0000_0008);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_w1c_lag: irq=%b expected 1", irq);
    end
    tick();
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_w1c: irq=%b expected 0", irq);
    end
  endtask

  task automatic test_edge_any();
    bus_write(0, GPIO_ADDR_ANY, 4'b0001, 32'h0000_0001);
    bus_read(0, GPIO_ADDR_ANY, 32'h0000_0001, "any_read");
    pins[0] = 1'b0;
    repeat (3) tick();
    bus_read(0, GPIO_ADDR_STATUS, 32'h0000_0001, "any_fall");
    bus_write(0, GPIO_ADDR_STATUS, 4'b0001, 32'h0000_0001);
    bus_read(0, GPIO_ADDR_STATUS, 32'h0, "any_cleared");
    pins[0] = 1'b1;
    repeat (2) tick();
    bus_write(0, GPIO_ADDR_STATUS, 4'b0001, 32'h0000_0001);
    bus_read(0, GPIO_ADDR_STATUS, 32'h0000_0001, "set_beats_w1c");
  endtask
`else
  task automatic test_level();
    pins[5] = 1'b0;
    repeat (4) tick();
    bus_write(0, GPIO_ADDR_MASK, 4'b0011, 32'h0000_0020);
    tick();
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL level_idle: irq=%b expected 0", irq);
    end
    bus_write(0, GPIO_ADDR_POL, 4'b0011, 32'h0000_0020);
    repeat (2) tick();
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL level_low_active: irq=%b expected 1", irq);
    end
    pins[5] = 1'b1;
    repeat (3) tick();
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL level_lag: irq=%b expected 1 at k+2", irq);
    end
    tick();
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL level_release: irq=%b expected 0 at k+3", irq);
    end
    bus_read(0, GPIO_ADDR_STATUS, 32'h0000_FFDF, "level_status");
    bus_write(0, GPIO_ADDR_STATUS, 4'hF, 32'hFFFF_FFFF);
    bus_read(0, GPIO_ADDR_STATUS, 32'h0000_FFDF, "level_w1c_ignored");
    bus_write(0, GPIO_ADDR_ANY, 4'hF, 32'hFFFF_FFFF);
    bus_read(0, GPIO_ADDR_ANY, 32'h0, "level_any_zero");
  endtask
`endif

  task automatic test_width8();
    bus_write(1, GPIO_ADDR_TRISTATE, 4'hF, 32'hFFFF_FFFF);
    checks++;
    if (tri8 !== 8'hFF) begin
      errors++;
      $display("FAIL w8_tristate_out: tri=%h expected ff", tri8);
    end
    bus_read(1, GPIO_ADDR_TRISTATE, 32'h0000_00FF, "w8_tristate_read");
  endtask

  initial begin
    test_reset();
    test_byte_write();
    test_readonly();
`ifdef GPIO_EDGE_IRQ_EN
    test_edge_rise();
    test_edge_any();
`else
    test_level();
`endif
    test_width8();
    repeat (2) tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d reads never answered", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
